// File: rtl/serial_parity_unit.sv
// Serial XOR-reduction: folds DATA_W accepted bits into one registered parity bit per frame.
// Optional expected-parity compare is compiled in with `define SERIAL_PARITY_CHECK_EN.
module serial_parity_unit #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         in_valid,
  input  logic                         in_bit,
`ifdef SERIAL_PARITY_CHECK_EN
  input  logic                         exp_parity,
  output logic                         parity_err,
`endif
  output logic                         busy,
  output logic [$clog2(DATA_W+1)-1:0]  bit_cnt,
  output logic                         parity,
  output logic                         parity_valid,
  output logic [1:0]                   state_dbg
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);

  // Handshake: a beat is accepted on a rising edge in ACC when in_valid=1 and
  // abort=0; there is no back-pressure, so the source may stall freely.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            parity_q, parity_d;
  logic            err_q, err_d;
  logic            next_acc;
  logic            exp_bit;

`ifdef SERIAL_PARITY_CHECK_EN
  assign exp_bit = exp_parity;
`else
  assign exp_bit = 1'b0;
`endif

  assign next_acc = acc_q ^ in_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACC;
          acc_d   = (ODD != 0);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_ACC: begin
        // Abort wins over a simultaneous beat, even the final one.
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (in_valid) begin
          acc_d = next_acc;
          if (cnt_q == LAST_CNT) begin
            parity_d = next_acc;
            err_d    = next_acc ^ exp_bit;
            cnt_d    = FULL_CNT;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign parity_valid = (state_q == ST_DONE);
  assign bit_cnt      = cnt_q;
  assign parity       = parity_q;
  assign state_dbg    = state_q;

`ifdef SERIAL_PARITY_CHECK_EN
  assign parity_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q ^ exp_bit;
`endif

endmodule

// File: tb/tb_serial_parity_unit.sv
// Bench for serial_parity_unit: even instance (A) and odd instance (B), DATA_W=8, scoreboard on parity_valid.
module tb_serial_parity_unit;

  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 0, abort_a = 0, iv_a = 0, ib_a = 0, ep_a = 0;
  logic start_b = 0, abort_b = 0, iv_b = 0, ib_b = 0, ep_b = 0;
  logic busy_a, par_a, pv_a, busy_b, par_b, pv_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [1:0] st_a, st_b;
  logic err_a, err_b;

`ifndef SERIAL_PARITY_CHECK_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  serial_parity_unit #(.DATA_W(DW), .ODD(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .in_valid(iv_a), .in_bit(ib_a),
`ifdef SERIAL_PARITY_CHECK_EN
    .exp_parity(ep_a), .parity_err(err_a),
`endif
    .busy(busy_a), .bit_cnt(cnt_a), .parity(par_a),
    .parity_valid(pv_a), .state_dbg(st_a)
  );

  serial_parity_unit #(.DATA_W(DW), .ODD(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .in_valid(iv_b), .in_bit(ib_b),
`ifdef SERIAL_PARITY_CHECK_EN
    .exp_parity(ep_b), .parity_err(err_b),
`endif
    .busy(busy_b), .bit_cnt(cnt_b), .parity(par_b),
    .parity_valid(pv_b), .state_dbg(st_b)
  );

  int total = 0;
  int bad   = 0;
  // entry = {err, parity, bit_cnt}
  logic [CW+1:0] exp_q_a[$];
  logic [CW+1:0] exp_q_b[$];
  logic hold_a = 0, hold_b = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // {busy, parity_valid, parity, bit_cnt}
  function automatic logic [CW+2:0] obs(input bit b);
    return b ? {busy_b, pv_b, par_b, cnt_b} : {busy_a, pv_a, par_a, cnt_a};
  endfunction

  task automatic drive(input bit b, input logic st, input logic ab,
                       input logic iv, input logic ib, input logic ep);
    if (b) begin start_b = st; abort_b = ab; iv_b = iv; ib_b = ib; ep_b = ep; end
    else   begin start_a = st; abort_a = ab; iv_a = iv; ib_a = ib; ep_a = ep; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit b, input logic [DW-1:0] bits, input int stall,
                            input bit ab_last, input bit start_mid, input logic ep);
    logic acc;
    logic [CW+2:0] o;
    logic hold;
    acc  = b;
    hold = b ? hold_b : hold_a;
    drive(b, 1, 0, 0, 0, ep);
    tick();
    for (int i = 0; i < DW; i++) begin
      logic bt;
      bt = bits[DW-1-i];
      drive(b, (start_mid && i == 3), (ab_last && i == DW-1), 1, bt, ep);
      if (!(ab_last && i == DW-1)) acc = acc ^ bt;
      if (i == DW-1 && !ab_last) begin
        if (b) exp_q_b.push_back({acc != ep, acc, CW'(DW)});
        else   exp_q_a.push_back({acc != ep, acc, CW'(DW)});
      end
      tick();
      drive(b, 0, 0, 0, 0, ep);
      o = obs(b);
      if (i < DW-1) begin
        check("cnt_after_beat", int'(o[CW-1:0]), i + 1);
        check("parity_hold_in_frame", int'(o[CW]), int'(hold));
        for (int s = 0; s < stall; s++) begin
          drive(b, 0, 0, 0, logic'($urandom_range(0, 1)), ep);
          tick();
          o = obs(b);
          check("cnt_hold_stall", int'(o[CW-1:0]), i + 1);
          check("parity_hold_stall", int'(o[CW]), int'(hold));
        end
      end else if (ab_last) begin
        check("abort_busy", int'(o[CW+2]), 0);
        check("abort_cnt", int'(o[CW-1:0]), 0);
        check("abort_parity_kept", int'(o[CW]), int'(hold));
      end else begin
        check("done_pv_latency", int'(o[CW+1]), 1);
        check("done_cnt", int'(o[CW-1:0]), DW);
        check("done_parity", int'(o[CW]), int'(acc));
        if (b) hold_b = acc; else hold_a = acc;
        tick();
        o = obs(b);
        check("idle_after_done_busy", int'(o[CW+2]), 0);
        check("idle_after_done_pv", int'(o[CW+1]), 0);
        check("idle_cnt_holds_full", int'(o[CW-1:0]), DW);
      end
    end
  endtask

  task automatic mon(input bit b, input logic pv, input logic par,
                     input logic [CW-1:0] cnt, input logic err);
    logic [CW+1:0] e;
    if (pv) begin
      if ((b ? exp_q_b.size() : exp_q_a.size()) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse dut=%0d: got parity_valid=1 expected none at %0t", b, $time);
      end else begin
        e = b ? exp_q_b.pop_front() : exp_q_a.pop_front();
        check(b ? "sb_parity_b" : "sb_parity_a", int'(par), int'(e[CW]));
        check(b ? "sb_cnt_b" : "sb_cnt_a", int'(cnt), int'(e[CW-1:0]));
`ifdef SERIAL_PARITY_CHECK_EN
        check(b ? "sb_err_b" : "sb_err_a", int'(err), int'(e[CW+1]));
`else
        if (err !== 1'b0) check("sb_err_tied", int'(err), 0);
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, pv_a, par_a, cnt_a, err_a);
      mon(1, pv_b, par_b, cnt_b, err_b);
    end
  end

  initial begin
    logic [CW+2:0] o;
    repeat (3) @(posedge clk);
    #1;
    o = obs(0);
    check("rst_state_a", int'(o), 0);
    o = obs(1);
    check("rst_state_b", int'(o), 0);
    rst = 0;
    tick();
    check("post_rst_busy_a", int'(busy_a), 0);

    // in_valid in IDLE is ignored
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 1, 0);
      tick();
      check("idle_iv_cnt", int'(cnt_a), 0);
      check("idle_iv_busy", int'(busy_a), 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // even frames, back to back; second carries a start pulse mid-frame
    send_frame(0, 8'b10110010, 0, 0, 0, 1'b1);
    send_frame(0, 8'b11100000, 0, 0, 1, 1'b1);
    // abort on the final beat: no pulse, parity keeps 1
    send_frame(0, 8'b11111111, 0, 1, 0, 1'b0);
    tick();
    check("abort_pv_quiet", int'(pv_a), 0);
    check("abort_parity_still", int'(par_a), 1);

    // asynchronous reset after three beats
    drive(0, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #3 rst = 1;
    #1;
    o = obs(0);
    check("async_rst_outputs", int'(o), 0);
    #2 rst = 0;
    hold_a = 0;
    repeat (3) begin
      tick();
      check("post_rst_no_pulse", int'(pv_a), 0);
    end

    send_frame(0, 8'b01000000, 0, 0, 0, 1'b1);

    // odd instance: stalls of two cycles between beats, then a dense frame
    send_frame(1, 8'b10000000, 2, 0, 0, 1'b0);
    send_frame(1, 8'b11000000, 0, 0, 0, 1'b1);

    repeat (4) tick();
    check("queue_a_drained", exp_q_a.size(), 0);
    check("queue_b_drained", exp_q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
